// File: rtl/rams_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// Holds the FSM state encoding, the default build widths and a small
// modulo helper used for round-robin pointer arithmetic.
package rams_arb_pkg;

    localparam int DEF_NUM_REQ       = 2;
    localparam int DEF_MEM_WIDTH     = 32;
    localparam int DEF_MEM_DEPTH     = 1024;
    localparam int DEF_PROTECT_LIMIT = 13;
    localparam int DEF_AW            = $clog2(DEF_MEM_DEPTH);
    localparam int DEF_PW            = $clog2(DEF_NUM_REQ);

    // INIT: one cycle of RAM output-register clear after reset.
    // IDLE: arbitrate requesters. CLEAR: zero-fill a range, one word per cycle.
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // One-hot grant vector for the default requester count.
    typedef logic [DEF_NUM_REQ-1:0] grant_t;

    // Wraps v into [0, n) assuming v < 2*n, which holds for ptr+offset sums.
    function automatic int unsigned rr_wrap(int unsigned v, int unsigned n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/rams_sp_arbiter_if.sv
// Requester-side bus of the RAM arbiter.
// Handshake: a requester holds req_valid[i] with stable write/address/data
// until it sees req_ready[i]; the access transfers in the cycle where both
// are high. req_ready is one-hot. For reads, rsp_valid[i] is high for one
// cycle exactly one cycle after the transfer and rsp_data is valid then;
// rsp_valid has no back-pressure.
interface rams_sp_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int MEM_WIDTH = 32,
    parameter int AW        = 10
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                req_write;
    logic [NUM_REQ-1:0][AW-1:0]        req_address;
    logic [NUM_REQ-1:0][MEM_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [MEM_WIDTH-1:0]              rsp_data;

    modport master (
        output req_valid, req_write, req_address, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_address, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rams_sp_arbiter_rr_arbiter.sv
// Round-robin grant selection: picks the first valid requester at or after
// the pointer, searching upward with wrap-around. Purely combinational.
module rr_arbiter
    import rams_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int PW      = $clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      grant_idx,
    output logic               grant_any
);

    logic [PW-1:0] idx;

    // Scan requesters in priority order starting at the pointer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'(rr_wrap(int'(ptr) + k, NUM_REQ));
            if (!grant_any && valid[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/rams_sp_arbiter.sv
// Shares one single-port RAM (registered read, enable/write_en/reset pins)
// among NUM_REQ requesters with round-robin arbitration, clears the RAM
// output register after reset and runs a zero-fill range clear on command.
// Optional feature macro: RAMS_ARB_WRITE_PROTECT_EN -- drops requester
// writes and clear writes to addresses below PROTECT_LIMIT.
module rams_sp_arbiter
    import rams_arb_pkg::*;
#(
    parameter  int NUM_REQ       = DEF_NUM_REQ,
    parameter  int MEM_WIDTH     = DEF_MEM_WIDTH,
    parameter  int MEM_DEPTH     = DEF_MEM_DEPTH,
    parameter  int PROTECT_LIMIT = DEF_PROTECT_LIMIT,
    localparam int AW            = $clog2(MEM_DEPTH)
)(
    input  logic                 clock,
    input  logic                 reset,
    rams_sp_arbiter_if.slave     bus,
    input  logic                 clr_start,
    input  logic [AW-1:0]        clr_base,
    input  logic [AW:0]          clr_len,
    output logic                 clr_busy,
    output logic                 clr_done,
    output logic                 wr_blocked,
    output logic                 ram_enable,
    output logic                 ram_write_en,
    output logic                 ram_reset,
    output logic [AW-1:0]        ram_address,
    output logic [MEM_WIDTH-1:0] ram_data_in,
    input  logic [MEM_WIDTH-1:0] ram_data_out,
    output state_t               dbg_state
);

    localparam int PW = $clog2(NUM_REQ);

`ifdef RAMS_ARB_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    state_t               state;
    logic [PW-1:0]        rr_ptr;
    logic [AW-1:0]        clr_addr;
    logic [AW:0]          clr_left;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 clr_busy_q;
    logic                 clr_done_q;
    logic                 wr_blocked_q;

    logic [NUM_REQ-1:0]   grant;
    logic [PW-1:0]        grant_idx;
    logic                 grant_any;
    logic                 serve;
    logic                 transfer;
    logic                 sel_write;
    logic [AW-1:0]        sel_addr;
    logic [MEM_WIDTH-1:0] sel_data;
    logic                 wr_prot;
    logic                 clr_prot;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .valid     (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Requests are served only in IDLE, out of reset, and not while a clear
    // is being launched (clear start wins the cycle).
    assign serve         = reset && (state == IDLE) && !clr_start;
    assign transfer      = serve && grant_any;
    assign bus.req_ready = serve ? grant : '0;

    assign sel_write = bus.req_write[grant_idx];
    assign sel_addr  = bus.req_address[grant_idx];
    assign sel_data  = bus.req_data[grant_idx];

    assign wr_prot  = PROT_EN && sel_write && (32'(sel_addr) < 32'(PROTECT_LIMIT));
    assign clr_prot = PROT_EN && (32'(clr_addr) < 32'(PROTECT_LIMIT));

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = ram_data_out;
    assign clr_busy      = clr_busy_q;
    assign clr_done      = clr_done_q;
    assign wr_blocked    = wr_blocked_q;
    assign dbg_state     = state;

    // RAM pin drive: all quiet while reset is asserted, then by state.
    always_comb begin
        ram_enable   = 1'b0;
        ram_write_en = 1'b0;
        ram_reset    = 1'b0;
        ram_address  = '0;
        ram_data_in  = '0;
        if (reset) begin
            case (state)
                INIT: begin
                    ram_enable = 1'b1;
                    ram_reset  = 1'b1;
                end
                IDLE: begin
                    if (transfer) begin
                        ram_enable   = 1'b1;
                        ram_write_en = sel_write && !wr_prot;
                        ram_address  = sel_addr;
                        ram_data_in  = sel_data;
                    end
                end
                CLEAR: begin
                    ram_enable   = !clr_prot;
                    ram_write_en = !clr_prot;
                    ram_address  = clr_addr;
                end
                default: ;
            endcase
        end
    end

    // Control FSM: state, round-robin pointer, clear counter, response tag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= INIT;
            rr_ptr       <= '0;
            clr_addr     <= '0;
            clr_left     <= '0;
            rsp_valid_q  <= '0;
            clr_busy_q   <= 1'b0;
            clr_done_q   <= 1'b0;
            wr_blocked_q <= 1'b0;
        end else begin
            rsp_valid_q  <= '0;
            clr_done_q   <= 1'b0;
            wr_blocked_q <= 1'b0;
            case (state)
                INIT: begin
                    state <= IDLE;
                end
                IDLE: begin
                    if (clr_start) begin
                        clr_addr <= clr_base;
                        clr_left <= clr_len;
                        if (clr_len == '0) begin
                            clr_done_q <= 1'b1;
                        end else begin
                            state      <= CLEAR;
                            clr_busy_q <= 1'b1;
                        end
                    end else if (grant_any) begin
                        rr_ptr       <= PW'(rr_wrap(32'(grant_idx) + 1, NUM_REQ));
                        rsp_valid_q  <= sel_write ? '0 : grant;
                        wr_blocked_q <= wr_prot;
                    end
                end
                CLEAR: begin
                    clr_addr <= (clr_addr == AW'(MEM_DEPTH - 1)) ? '0 : clr_addr + 1'b1;
                    clr_left <= clr_left - 1'b1;
                    if (clr_left == (AW+1)'(1)) begin
                        state      <= IDLE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule
